// File: rtl/baser_tx_scrambler_gbx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// baser_tx_scrambler_gbx - 64b/66b TX scrambler (x^58+x^39+1), 66:64 gearbox
// sequencer, idle substitution; PRBS31 pattern under BASER_TX_PRBS31_EN. Rev 1.0
// ============================================================================
module baser_tx_scrambler_gbx #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  parameter int SEQ_PERIOD = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef BASER_TX_PRBS31_EN
  input  logic                  cfg_tx_prbs31_enable,
`endif
  input  logic [DATA_WIDTH-1:0] encoded_tx_data,
  input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
  input  logic                  encoded_tx_valid,
  output logic                  encoded_tx_ready,
  output logic [DATA_WIDTH-1:0] serdes_tx_data,
  output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
  output logic [5:0]            serdes_tx_seq,
  output logic                  serdes_tx_pause,
  output logic                  tx_underflow
);

  localparam int                    c_scr_w     = 58;
  localparam logic [c_scr_w-1:0]    c_scr_seed  = '1;
  localparam logic [DATA_WIDTH-1:0] c_idle_data = 'h1E;
  localparam logic [HDR_WIDTH-1:0]  c_hdr_ctrl  = 'b01;
  localparam logic [5:0]            c_last_seq  = 6'(SEQ_PERIOD - 1);

  generate
    if (DATA_WIDTH != 64) begin : g_bad_data_width
      $error("baser_tx_scrambler_gbx: DATA_WIDTH must be 64");
    end
    if (HDR_WIDTH != 2) begin : g_bad_hdr_width
      $error("baser_tx_scrambler_gbx: HDR_WIDTH must be 2");
    end
    if (SEQ_PERIOD < 2 || SEQ_PERIOD > 64) begin : g_bad_seq_period
      $error("baser_tx_scrambler_gbx: SEQ_PERIOD must be 2..64");
    end
  endgenerate

  logic [5:0]            seq_q, seq_d;
  logic [c_scr_w-1:0]    scr_q, scr_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [HDR_WIDTH-1:0]  tx_hdr_q, tx_hdr_d;
  logic [5:0]            tx_seq_q, tx_seq_d;
  logic                  tx_pause_q, tx_pause_d;
  logic                  underflow_q, underflow_d;

  logic [DATA_WIDTH-1:0] blk_data;
  logic [HDR_WIDTH-1:0]  blk_hdr;
  logic [DATA_WIDTH-1:0] scr_out;
  logic [c_scr_w-1:0]    scr_work;
  logic                  pause_cycle;

  assign pause_cycle      = (seq_q == c_last_seq);
  assign encoded_tx_ready = rst_n && !pause_cycle;

  assign blk_data = encoded_tx_valid ? encoded_tx_data : c_idle_data;
  assign blk_hdr  = encoded_tx_valid ? encoded_tx_hdr  : c_hdr_ctrl;

  // Self-synchronous scrambler, bit 0 first; state shifts in scrambled bits.
  always_comb begin
    scr_work = scr_q;
    scr_out  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      scr_out[i] = blk_data[i] ^ scr_work[38] ^ scr_work[57];
      scr_work   = {scr_work[c_scr_w-2:0], scr_out[i]};
    end
  end

`ifdef BASER_TX_PRBS31_EN
  localparam int c_blk_w = DATA_WIDTH + HDR_WIDTH;

  logic [30:0]        prbs_q, prbs_d, prbs_work;
  logic [c_blk_w-1:0] prbs_bits;

  // 66 PRBS31 bits per block; bits [1:0] become the header.
  always_comb begin
    prbs_work = prbs_q;
    prbs_bits = '0;
    for (int i = 0; i < c_blk_w; i++) begin
      prbs_bits[i] = prbs_work[30] ^ prbs_work[27];
      prbs_work    = {prbs_work[29:0], prbs_bits[i]};
    end
  end
`endif

  always_comb begin
    seq_d       = pause_cycle ? '0 : seq_q + 6'd1;
    scr_d       = scr_q;
    tx_data_d   = tx_data_q;
    tx_hdr_d    = tx_hdr_q;
    tx_seq_d    = seq_q;
    tx_pause_d  = 1'b0;
    underflow_d = 1'b0;
`ifdef BASER_TX_PRBS31_EN
    prbs_d      = prbs_q;
`endif
    if (pause_cycle) begin
      tx_pause_d = 1'b1;
    end
`ifdef BASER_TX_PRBS31_EN
    else if (cfg_tx_prbs31_enable) begin
      prbs_d    = prbs_work;
      tx_hdr_d  = prbs_bits[HDR_WIDTH-1:0];
      tx_data_d = prbs_bits[c_blk_w-1:HDR_WIDTH];
    end
`endif
    else begin
      scr_d       = scr_work;
      tx_data_d   = scr_out;
      tx_hdr_d    = blk_hdr;
      underflow_d = !encoded_tx_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_q       <= '0;
      scr_q       <= c_scr_seed;
      tx_data_q   <= '0;
      tx_hdr_q    <= c_hdr_ctrl;
      tx_seq_q    <= '0;
      tx_pause_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifdef BASER_TX_PRBS31_EN
      prbs_q      <= '1;
`endif
    end else begin
      seq_q       <= seq_d;
      scr_q       <= scr_d;
      tx_data_q   <= tx_data_d;
      tx_hdr_q    <= tx_hdr_d;
      tx_seq_q    <= tx_seq_d;
      tx_pause_q  <= tx_pause_d;
      underflow_q <= underflow_d;
`ifdef BASER_TX_PRBS31_EN
      prbs_q      <= prbs_d;
`endif
    end
  end

  assign serdes_tx_data  = tx_data_q;
  assign serdes_tx_hdr   = tx_hdr_q;
  assign serdes_tx_seq   = tx_seq_q;
  assign serdes_tx_pause = tx_pause_q;
  assign tx_underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_baser_tx_scrambler_gbx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_baser_tx_scrambler_gbx - scoreboard bench: expected blocks queued at drive
// time, output descrambled by a reference descrambler and compared. Rev 1.0
// ============================================================================
module tb_baser_tx_scrambler_gbx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] encoded_tx_data;
  logic [1:0]  encoded_tx_hdr;
  logic        encoded_tx_valid;
  logic        encoded_tx_ready;
  logic [63:0] serdes_tx_data;
  logic [1:0]  serdes_tx_hdr;
  logic [5:0]  serdes_tx_seq;
  logic        serdes_tx_pause;
  logic        tx_underflow;
`ifdef BASER_TX_PRBS31_EN
  logic        cfg_tx_prbs31_enable = 1'b0;
  logic        prbs_mode = 1'b0;
  logic [30:0] prbs_state = '1;
`endif

  always #5 clk = ~clk;

  baser_tx_scrambler_gbx dut (
    .clk              (clk),
    .rst_n            (rst_n),
`ifdef BASER_TX_PRBS31_EN
    .cfg_tx_prbs31_enable (cfg_tx_prbs31_enable),
`endif
    .encoded_tx_data  (encoded_tx_data),
    .encoded_tx_hdr   (encoded_tx_hdr),
    .encoded_tx_valid (encoded_tx_valid),
    .encoded_tx_ready (encoded_tx_ready),
    .serdes_tx_data   (serdes_tx_data),
    .serdes_tx_hdr    (serdes_tx_hdr),
    .serdes_tx_seq    (serdes_tx_seq),
    .serdes_tx_pause  (serdes_tx_pause),
    .tx_underflow     (tx_underflow)
  );

  typedef struct packed {
    logic        raw;
    logic        uf;
    logic [1:0]  hdr;
    logic [63:0] data;
  } exp_t;

  localparam logic [63:0] c_first_ref = 64'h03FF_FF80_0000_0000;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [5:0]  model_seq = '0;
  logic [57:0] ds_state = '1;
  logic [63:0] last_data = '0;
  logic [1:0]  last_hdr = 2'b01;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

`ifdef BASER_TX_PRBS31_EN
  task automatic prbs_gen(output logic [1:0] h, output logic [63:0] d);
    logic [65:0] bits;
    for (int i = 0; i < 66; i++) begin
      bits[i]    = prbs_state[30] ^ prbs_state[27];
      prbs_state = {prbs_state[29:0], bits[i]};
    end
    h = bits[1:0];
    d = bits[65:2];
  endtask
`endif

  task automatic check_out(input logic pause_cyc, input logic [5:0] seq_exp);
    exp_t        e;
    logic [63:0] plain;
    logic [63:0] rx;
    check_val("seq", serdes_tx_seq, seq_exp);
    check_val("pause", serdes_tx_pause, pause_cyc);
    if (pause_cyc) begin
      check_val("pause_data_hold", serdes_tx_data, last_data);
      check_val("pause_hdr_hold", serdes_tx_hdr, last_hdr);
      check_val("pause_underflow", tx_underflow, 0);
    end else if (sb.size() == 0) begin
      check_val("sb_depth", sb.size(), 1);
    end else begin
      e = sb.pop_front();
`ifdef BASER_TX_PRBS31_EN
      if (e.raw) begin
        check_val("prbs_hdr", serdes_tx_hdr, e.hdr);
        check_val("prbs_data", serdes_tx_data, e.data);
        check_val("prbs_underflow", tx_underflow, 0);
      end else
`endif
      begin
        rx = serdes_tx_data;
        for (int i = 0; i < 64; i++) begin
          plain[i] = rx[i] ^ ds_state[38] ^ ds_state[57];
          ds_state = {ds_state[56:0], rx[i]};
        end
        check_val("hdr", serdes_tx_hdr, e.hdr);
        check_val("payload", plain, e.data);
        check_val("underflow", tx_underflow, e.uf);
      end
    end
    last_data = serdes_tx_data;
    last_hdr  = serdes_tx_hdr;
  endtask

  // Called at posedge+1; applies inputs, queues the expectation, advances one clock.
  task automatic drive_cycle(input logic v, input logic [1:0] h, input logic [63:0] d,
                             output logic taken);
    exp_t       e;
    logic       pause_cyc;
    logic [5:0] seq_now;
    encoded_tx_valid = v;
    encoded_tx_hdr   = h;
    encoded_tx_data  = d;
    #1;
    seq_now   = model_seq;
    pause_cyc = (model_seq == 6'd32);
    check_val("ready", encoded_tx_ready, !pause_cyc);
    if (!pause_cyc) begin
      e = '0;
`ifdef BASER_TX_PRBS31_EN
      if (prbs_mode) begin
        e.raw = 1'b1;
        prbs_gen(e.hdr, e.data);
      end else
`endif
      begin
        e.uf   = !v;
        e.hdr  = v ? h : 2'b01;
        e.data = v ? d : 64'h1E;
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check_out(pause_cyc, seq_now);
    model_seq = pause_cyc ? 6'd0 : model_seq + 6'd1;
    taken = v && !pause_cyc;
  endtask

  task automatic check_reset_outputs();
    check_val("rst_data", serdes_tx_data, 0);
    check_val("rst_hdr", serdes_tx_hdr, 2'b01);
    check_val("rst_seq", serdes_tx_seq, 0);
    check_val("rst_pause", serdes_tx_pause, 0);
    check_val("rst_underflow", tx_underflow, 0);
    check_val("rst_ready", encoded_tx_ready, 0);
  endtask

  task automatic model_reset();
    model_seq = '0;
    ds_state  = '1;
    last_data = '0;
    last_hdr  = 2'b01;
    sb.delete();
  endtask

  initial begin
    logic        taken;
    logic [1:0]  bh;
    logic [63:0] bd;
    int          n_taken;
    int          guard;

    rst_n = 1'b0;
    encoded_tx_valid = 1'b0;
    encoded_tx_hdr   = 2'b01;
    encoded_tx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    model_reset();

    drive_cycle(1'b1, 2'b10, 64'h0, taken);
    check_val("first_blk", serdes_tx_data, c_first_ref);

    // Two consecutive idle substitutions on normal cycles.
    drive_cycle(1'b0, 2'b10, 64'hDEAD_BEEF, taken);
    check_val("uf_pulse_1", tx_underflow, 1);
    drive_cycle(1'b0, 2'b10, 64'hDEAD_BEEF, taken);
    check_val("uf_pulse_2", tx_underflow, 1);

    // Sequence-numbered random stream; a held block must be re-offered after a pause.
    n_taken = 0;
    guard   = 0;
    bh = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
    bd = {32'(n_taken), 32'($urandom)};
    while (n_taken < 1000 && guard < 1200) begin
      drive_cycle(1'b1, bh, bd, taken);
      guard++;
      if (taken) begin
        n_taken++;
        bh = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        bd = {32'(n_taken), 32'($urandom)};
      end
    end
    check_val("stream_count", n_taken, 1000);

    // Valid gap landing on the pause cycle must not pulse underflow.
    guard = 0;
    while (model_seq != 6'd32 && guard < 40) begin
      drive_cycle(1'b1, 2'b10, {32'hA5A5_0000, 32'(guard)}, taken);
      guard++;
    end
    drive_cycle(1'b0, 2'b10, 64'h0, taken);
    check_val("pause_gap_uf", tx_underflow, 0);
    drive_cycle(1'b1, 2'b01, 64'h1234_5678_9ABC_DEF0, taken);

    // Mid-run reset at internal seq 17.
    guard = 0;
    while (model_seq != 6'd17 && guard < 40) begin
      drive_cycle(1'b1, 2'b10, {32'h5A5A_0000, 32'(guard)}, taken);
      guard++;
    end
    check_val("reached_seq17", model_seq, 17);
    rst_n = 1'b0;
    #1;
    check_val("midrst_ready", encoded_tx_ready, 0);
    @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    model_reset();
    drive_cycle(1'b1, 2'b10, 64'h0, taken);
    check_val("first_blk_after_rst", serdes_tx_data, c_first_ref);

`ifdef BASER_TX_PRBS31_EN
    cfg_tx_prbs31_enable = 1'b1;
    prbs_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 2'b10, {32'(i), 32'($urandom)}, taken);
    end
    cfg_tx_prbs31_enable = 1'b0;
    prbs_mode = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
